dispense_sequencer: RTL and testbench

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

---
 rtl/dispense_sequencer.sv | 155 +++++++++++++++
 tb/tb_dispense_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sequencer.sv
// dispense_sequencer
//   Vending-machine slot dispenser. A request in IDLE latches a slot and runs
//   up to 1+MAX_RETRY spin attempts. Each attempt drives the motor for
//   MOTOR_CYCLES cycles and then waits DROP_TIMEOUT cycles for the drop
//   sensor. A drop ends the sequence with a done pulse. If every attempt
//   times out, the sequence ends with a jam pulse and the slot is disabled.
//
// Ports
//   clock, rst           : clock; asynchronous active-high reset
//   vend_req, slot_code  : dispense request and slot (0..19 legal), IDLE only
//   drop_sensor          : item-fell indication
//   clear_jams           : clears every slot_disable bit
//   req_ready, busy      : IDLE / not-IDLE
//   motor_en, motor_sel  : motor drive and the slot it targets (0 when off)
//   done, jam, reject    : one-cycle result pulses
//   jam_slot             : last slot that jammed
//   slot_disable         : sticky per-slot jam flags
module dispense_sequencer #(
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        vend_req,
    input  logic [4:0]  slot_code,
    input  logic        drop_sensor,
    input  logic        clear_jams,
    output logic        req_ready,
    output logic        busy,
    output logic        motor_en,
    output logic [4:0]  motor_sel,
    output logic        done,
    output logic        jam,
    output logic        reject,
    output logic [4:0]  jam_slot,
    output logic [19:0] slot_disable
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_WAIT_DROP,
        S_DONE,
        S_JAM
    } state_t;

    localparam logic [7:0] SPIN_LAST = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(DROP_TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic [7:0]  timer_q, timer_d;
    logic [2:0]  retry_q, retry_d;
    logic        reject_q, reject_d;
    logic [4:0]  jam_slot_q, jam_slot_d;
    logic [19:0] sdis_q, sdis_d;

    logic slot_legal;
    logic slot_blocked;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            reject_q   <= 1'b0;
            jam_slot_q <= '0;
            sdis_q     <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            reject_q   <= reject_d;
            jam_slot_q <= jam_slot_d;
            sdis_q     <= sdis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        reject_d   = 1'b0;
        jam_slot_d = jam_slot_q;
        // Clear applies first so a same-cycle JAM set below wins for its bit,
        // and so an IDLE request sees the slot as already re-enabled.
        sdis_d     = clear_jams ? '0 : sdis_q;

        slot_legal   = (slot_code <= 5'd19);
        slot_blocked = slot_legal ? sdis_d[slot_code] : 1'b0;

        case (state_q)
            S_IDLE: begin
                if (vend_req) begin
                    if (slot_legal && !slot_blocked) begin
                        state_d = S_SPIN;
                        slot_d  = slot_code;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_SPIN: begin
                if (drop_sensor) begin
                    state_d = S_DONE;
                end else if (timer_q == SPIN_LAST) begin
                    state_d = S_WAIT_DROP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WAIT_DROP: begin
                // Drop is checked before the timeout so a late drop still wins.
                if (drop_sensor) begin
                    state_d = S_DONE;
                end else if (timer_q == WAIT_LAST) begin
                    timer_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = S_SPIN;
                        retry_d = retry_q + 3'd1;
                    end else begin
                        state_d            = S_JAM;
                        jam_slot_d         = slot_q;
                        sdis_d[slot_q]     = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_JAM:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: decoded from state or taken straight from registers.
    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign motor_en     = (state_q == S_SPIN);
    assign motor_sel    = (state_q == S_SPIN) ? slot_q : 5'd0;
    assign done         = (state_q == S_DONE);
    assign jam          = (state_q == S_JAM);
    assign reject       = reject_q;
    assign jam_slot     = jam_slot_q;
    assign slot_disable = sdis_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
module tb_dispense_sequencer;

    localparam int MC = 8;
    localparam int DT = 16;
    localparam int MR = 2;
    localparam int P  = MC + DT;          // cycles per spin attempt
    localparam int W  = (1 + MR) * P;     // cycles from first spin to jam

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        vend_req = 1'b0;
    logic [4:0]  slot_code = '0;
    logic        drop_sensor = 1'b0;
    logic        clear_jams = 1'b0;
    logic        req_ready, busy, motor_en, done, jam, reject;
    logic [4:0]  motor_sel, jam_slot;
    logic [19:0] slot_disable;

    int checks = 0;
    int failures = 0;

    dispense_sequencer #(
        .MOTOR_CYCLES(MC),
        .DROP_TIMEOUT(DT),
        .MAX_RETRY(MR)
    ) dut (
        .clock(clock),
        .rst(rst),
        .vend_req(vend_req),
        .slot_code(slot_code),
        .drop_sensor(drop_sensor),
        .clear_jams(clear_jams),
        .req_ready(req_ready),
        .busy(busy),
        .motor_en(motor_en),
        .motor_sel(motor_sel),
        .done(done),
        .jam(jam),
        .reject(reject),
        .jam_slot(jam_slot),
        .slot_disable(slot_disable)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scenario table: one request per record, with the cycle numbers at which
    // each result pulse must appear (-1 = never) and the motor-on cycle count.
    typedef struct {
        logic [4:0] slot;
        bit         clr;
        int         drop_cyc;
        int         exp_done;
        int         exp_jam;
        int         exp_rej;
        int         exp_motor;
    } scn_t;

    scn_t scn[9];

    // Reference model: elapsed cycles since acceptance plus result flags.
    int          m_e;
    int          m_slot;
    int          m_jslot;
    bit          m_done, m_jam, m_rej;
    logic [19:0] m_sdis;

    function automatic logic [63:0] model_out();
        logic        men;
        logic        mbusy;
        logic [4:0]  msel;
        men   = (m_e >= 0) && ((m_e % P) < MC);
        msel  = men ? 5'(m_slot) : 5'd0;
        mbusy = (m_e >= 0) || m_done || m_jam;
        return {24'd0, !mbusy, mbusy, men, msel, m_done, m_jam, m_rej, 5'(m_jslot), m_sdis};
    endfunction

    function automatic logic [63:0] dut_out();
        return {24'd0, req_ready, busy, motor_en, motor_sel, done, jam, reject, jam_slot, slot_disable};
    endfunction

    task automatic model_step(input bit vend, input int sc, input bit drop, input bit clr);
        bit          nd, nj, nr;
        logic [19:0] ns;
        nd = 0; nj = 0; nr = 0;
        ns = clr ? 20'd0 : m_sdis;
        if (m_e >= 0) begin
            if (drop) begin
                nd  = 1;
                m_e = -1;
            end else if (m_e == W - 1) begin
                nj         = 1;
                m_e        = -1;
                m_jslot    = m_slot;
                ns[m_slot] = 1'b1;
            end else begin
                m_e++;
            end
        end else if (!m_done && !m_jam && vend) begin
            if (sc <= 19 && !ns[sc]) begin
                m_e    = 0;
                m_slot = sc;
            end else begin
                nr = 1;
            end
        end
        m_sdis = ns;
        m_done = nd;
        m_jam  = nj;
        m_rej  = nr;
    endtask

    initial begin
        int done_c, jam_c, rej_c, motor_n, sel_bad, end_c, ready_c, o;
        int sc;
        bit v, d, c;

        scn[0] = '{5'd5,  1'b0, 12, 13, -1, -1, 8};   // normal dispense
        scn[1] = '{5'd17, 1'b0, -1, -1, 73, -1, 24};  // all retries time out
        scn[2] = '{5'd17, 1'b0, -1, -1, -1,  1, 0};   // jammed slot refused
        scn[3] = '{5'd20, 1'b0, -1, -1, -1,  1, 0};   // illegal slot
        scn[4] = '{5'd17, 1'b1,  3,  4, -1, -1, 3};   // clear + request, early drop
        scn[5] = '{5'd1,  1'b0, 24, 25, -1, -1, 8};   // drop on last wait cycle
        scn[6] = '{5'd0,  1'b0, 25, 26, -1, -1, 9};   // drop on first retry spin cycle
        scn[7] = '{5'd19, 1'b0, 72, 73, -1, -1, 24};  // drop on final timeout cycle
        scn[8] = '{5'd31, 1'b0, -1, -1, -1,  1, 0};   // illegal slot, top code

        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("reset_outputs", dut_out(), {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 20'd0});
        repeat (2) @(posedge clock);
        @(negedge clock) rst = 1'b0;

        // Table-driven scenarios
        for (int i = 0; i < 9; i++) begin
            done_c = -1; jam_c = -1; rej_c = -1; motor_n = 0; sel_bad = 0;
            end_c = -1; ready_c = -1;
            for (int cy = 0; cy < 96; cy++) begin
                vend_req    = (cy == 0);
                slot_code   = scn[i].slot;
                clear_jams  = (cy == 0) && scn[i].clr;
                drop_sensor = (cy == scn[i].drop_cyc);
                @(posedge clock);
                #1;
                o = cy + 1;
                if (motor_en) begin
                    motor_n++;
                    if (motor_sel !== scn[i].slot) sel_bad++;
                end else if (motor_sel !== 5'd0) begin
                    sel_bad++;
                end
                if (done && done_c < 0) done_c = o;
                if (jam && jam_c < 0) jam_c = o;
                if (reject && rej_c < 0) rej_c = o;
                if (end_c >= 0 && o == end_c + 1) begin
                    ready_c = req_ready ? o : -1;
                    break;
                end
                if (end_c < 0 && (done || jam || reject)) end_c = o;
            end
            vend_req = 1'b0; drop_sensor = 1'b0; clear_jams = 1'b0;
            chk($sformatf("scn%0d_done_cycle", i), 64'(done_c), 64'(scn[i].exp_done));
            chk($sformatf("scn%0d_jam_cycle", i), 64'(jam_c), 64'(scn[i].exp_jam));
            chk($sformatf("scn%0d_reject_cycle", i), 64'(rej_c), 64'(scn[i].exp_rej));
            chk($sformatf("scn%0d_motor_cycles", i), 64'(motor_n), 64'(scn[i].exp_motor));
            chk($sformatf("scn%0d_motor_sel_errs", i), 64'(sel_bad), 64'd0);
            chk($sformatf("scn%0d_ready_after", i), 64'(ready_c), 64'(end_c + 1));
            if (i == 1) begin
                chk("jam_slot_after_jam", 64'(jam_slot), 64'd17);
                chk("slot_disable_after_jam", 64'(slot_disable), 64'(20'h20000));
            end
            if (i == 4) begin
                chk("slot_disable_after_clear", 64'(slot_disable), 64'd0);
                chk("jam_slot_held", 64'(jam_slot), 64'd17);
            end
        end

        // Reset asserted in the 5th SPIN cycle
        vend_req = 1'b1; slot_code = 5'd3;
        @(posedge clock); #1;
        vend_req = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        chk("spin5_motor_on", 64'(motor_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midspin_reset_outputs", dut_out(), {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 20'd0});
        @(posedge clock); #1;
        chk("held_reset_outputs", dut_out(), {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 20'd0});
        @(negedge clock) rst = 1'b0;
        vend_req = 1'b1; slot_code = 5'd3;
        @(posedge clock); #1;
        vend_req = 1'b0;
        chk("post_reset_accept", {motor_en, motor_sel}, {1'b1, 5'd3});
        drop_sensor = 1'b1;
        @(posedge clock); #1;
        drop_sensor = 1'b0;
        chk("post_reset_done", 64'(done), 64'd1);
        @(posedge clock); #1;

        // Randomized run against the reference model
        rst = 1'b1;
        #2;
        @(negedge clock) rst = 1'b0;
        m_e = -1; m_slot = 0; m_jslot = 0; m_done = 0; m_jam = 0; m_rej = 0; m_sdis = '0;
        for (int cy = 0; cy < 3000; cy++) begin
            chk("random_outputs", dut_out(), model_out());
            v  = ($urandom_range(0, 2) == 0);
            sc = $urandom_range(0, 23);
            d  = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 79) == 0);
            vend_req = v; slot_code = 5'(sc); drop_sensor = d; clear_jams = c;
            model_step(v, sc, d, c);
            @(posedge clock);
            #1;
        end
        vend_req = 1'b0; drop_sensor = 1'b0; clear_jams = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
